dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have per requester n in {0 = CPU MEM stage, 1 = DMA/debug}: reqn in 1 request; wen in 1 write; addrn in 32 byte address; wdatan in 32 store data; lsn in 4 access type.
REQ-004 SHALL have per requester n: gntn out 1 request accepted; rvalidn out 1 access complete; rdatan out 32 load data; errn out 1 access rejected.
REQ-005 SHALL have memory side: mem_wr out 1; mem_addr out 32; mem_din out 32; mem_ls out 4; mem_dout in 32 (memory writes on posedge and returns read data by the following posedge).
REQ-006 SHALL decode ls codes as: 0000 word, 1000 half, 0100 byte, 0010 half unsigned, 0001 byte unsigned; any other code is illegal.

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-008 SHALL, in IDLE with any req high, assert exactly one gnt combinationally, latch the winner's we/addr/wdata/ls and index, and go to ACCESS.
REQ-009 SHALL, in ACCESS, drive mem_addr/mem_din/mem_ls from the latched values for exactly one cycle, with mem_wr = latched we AND NOT latched error.
REQ-010 SHALL, at the end of ACCESS, register mem_dout into the winner's rdata (loads only) and go to RESP.
REQ-011 SHALL, in RESP, pulse the winner's rvalid (and errn if rejected) for exactly one cycle, then return to IDLE.
REQ-012 SHALL give fixed latency: gnt in cycle T, rvalid in cycle T+2, next gnt no earlier than T+3.
REQ-013 SHALL keep mem_wr = 0 in IDLE and RESP; mem_addr/mem_din/mem_ls hold their last values outside ACCESS.
REQ-014 SHALL flag an error when the ls code is illegal, or when a word access has addr[1:0] != 00, or when a half access has addr[0] = 1.
REQ-015 SHALL, on error, suppress mem_wr, return rdata = 0, and assert errn together with rvalidn.
REQ-016 SHALL hold rdatan stable until that requester's next completed load; store completions leave rdatan unchanged.
REQ-017 SHALL ignore req of a requester changing while not granted; a requester must hold req until gnt, and may deassert or re-request from the cycle after gnt.
REQ-018 SHALL ignore a new req from the winner during ACCESS/RESP; it is considered only in the next IDLE.

Reset
REQ-019 SHALL, when rst is high at a rising edge, enter IDLE and clear mem_wr, mem_addr, mem_din, mem_ls, all gnt/rvalid/err, both rdata, the latched request, and the priority pointer (requester 0 preferred).
REQ-020 SHALL, on rst during ACCESS, clear mem_wr within that edge, so no write completes after reset, and emit no rvalid for the aborted access.

Configuration
REQ-021 SHALL use macro DM_ARB_RR_EN: defined -> round-robin; the pointer toggles to the non-winner after each grant, and simultaneous requests alternate.
REQ-022 SHALL, with DM_ARB_RR_EN undefined, use fixed priority (requester 0 always wins ties) and contain no pointer register.

Verification
REQ-023 SHALL cover: req0 store word addr 0x10 data 0xDEADBEEF, then load word 0x10 -> mem_wr=1 for one cycle; rvalid0 at T+2; rdata0 = 0xDEADBEEF.
REQ-024 SHALL cover: req0 and req1 both held high for 4 grants -> with DM_ARB_RR_EN: grants 0,1,0,1; without: 0,0,0,0 while req0 is held.
REQ-025 SHALL cover: req1 half load ls 1000 addr 0x13 -> no mem_wr; err1=1 with rvalid1; rdata1 = 0.
REQ-026 SHALL cover: req0 store ls 0110 (illegal) -> mem_wr stays 0; err0 pulses at T+2; memory contents unchanged.
REQ-027 SHALL cover: rst asserted during ACCESS of a store -> mem_wr=0 from that edge; no rvalid; state IDLE; next req granted one cycle after rst deasserts.
REQ-028 SHALL cover: req0 byte-unsigned load ls 0001 addr 0x11 with memory word 0x0000_8000 (mem_dout driven 0x00000080) -> rdata0 = 0x00000080, err0 = 0.

Source files
------------

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-requester data-memory arbiter with an IDLE/ACCESS/RESP access FSM
// Define DM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module dm_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic [3:0]  ls0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic [3:0]  ls1,
    output logic        gnt0,
    output logic        rvalid0,
    output logic [31:0] rdata0,
    output logic        err0,
    output logic        gnt1,
    output logic        rvalid1,
    output logic [31:0] rdata1,
    output logic        err1,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [3:0]  mem_ls,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      state_q;
    logic        idx_q;
    logic        we_q;
    logic        err_q;
    logic        mem_wr_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_din_q;
    logic [3:0]  mem_ls_q;
    logic [1:0]  rvalid_q;
    logic [1:0]  err_o_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    logic        pick1;
    logic        grant;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_ls;
    logic        sel_err;

    function automatic logic access_err(input logic [3:0] ls, input logic [1:0] a);
        case (ls)
            4'b0000:          return a != 2'b00;
            4'b1000, 4'b0010: return a[0];
            4'b0100, 4'b0001: return 1'b0;
            default:          return 1'b1;
        endcase
    endfunction

`ifdef DM_ARB_RR_EN
    logic ptr_q;
    assign pick1 = req1 && (!req0 || ptr_q);
`else
    assign pick1 = req1 && !req0;
`endif

    // Grant is combinational so the requester sees it in the cycle its request is taken.
    assign grant = (state_q == S_IDLE) && (req0 || req1) && !rst;
    assign gnt0  = grant && !pick1;
    assign gnt1  = grant && pick1;

    assign sel_we    = pick1 ? we1    : we0;
    assign sel_addr  = pick1 ? addr1  : addr0;
    assign sel_wdata = pick1 ? wdata1 : wdata0;
    assign sel_ls    = pick1 ? ls1    : ls0;
    assign sel_err   = access_err(sel_ls, sel_addr[1:0]);

    // Gating with rst keeps a write in flight from landing on the reset edge.
    assign mem_wr   = mem_wr_q && !rst;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_ls   = mem_ls_q;
    assign rvalid0  = rvalid_q[0];
    assign rvalid1  = rvalid_q[1];
    assign err0     = err_o_q[0];
    assign err1     = err_o_q[1];
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= 32'h0;
            mem_din_q  <= 32'h0;
            mem_ls_q   <= 4'h0;
            rvalid_q   <= 2'b00;
            err_o_q    <= 2'b00;
            rdata0_q   <= 32'h0;
            rdata1_q   <= 32'h0;
`ifdef DM_ARB_RR_EN
            ptr_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        idx_q      <= pick1;
                        we_q       <= sel_we;
                        err_q      <= sel_err;
                        mem_wr_q   <= sel_we && !sel_err;
                        mem_addr_q <= sel_addr;
                        mem_din_q  <= sel_wdata;
                        mem_ls_q   <= sel_ls;
                        state_q    <= S_ACCESS;
`ifdef DM_ARB_RR_EN
                        ptr_q      <= !pick1;
`endif
                    end
                end
                S_ACCESS: begin
                    mem_wr_q        <= 1'b0;
                    rvalid_q[idx_q] <= 1'b1;
                    err_o_q[idx_q]  <= err_q;
                    // Rejected accesses return zero; good stores leave rdata alone.
                    if (err_q || !we_q) begin
                        if (idx_q) rdata1_q <= err_q ? 32'h0 : mem_dout;
                        else       rdata0_q <= err_q ? 32'h0 : mem_dout;
                    end
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    rvalid_q <= 2'b00;
                    err_o_q  <= 2'b00;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - randomized self-checking bench for dm_arbiter against a transaction-level model
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [3:0]  ls0, ls1;
    logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_wr;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic [3:0]  mem_ls;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] phys  [64]  = '{default: 32'h0};
    logic [7:0]  ref_b [256] = '{default: 8'h0};
    int          gnt_log [$];

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ls0(ls0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ls1(ls1),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ls(mem_ls),
        .mem_dout(mem_dout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Memory behaviour: lane extraction and extension happen on the memory side.
    function automatic logic [31:0] phys_read(input logic [31:0] w, input logic [1:0] off, input logic [3:0] ls);
        logic [31:0] sh;
        sh = w >> (8 * off);
        case (ls)
            4'b0000: return w;
            4'b1000: return {{16{sh[15]}}, sh[15:0]};
            4'b0010: return {16'h0, sh[15:0]};
            4'b0100: return {{24{sh[7]}}, sh[7:0]};
            4'b0001: return {24'h0, sh[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] ls);
        case (ls)
            4'b0000:          return 32'hFFFF_FFFF;
            4'b1000, 4'b0010: return 32'h0000_FFFF;
            4'b0100, 4'b0001: return 32'h0000_00FF;
            default:          return 32'h0;
        endcase
    endfunction

    assign mem_dout = phys_read(phys[mem_addr[7:2]], mem_addr[1:0], mem_ls);

    always @(posedge clk) begin
        if (mem_wr)
            phys[mem_addr[7:2]] <= (phys[mem_addr[7:2]] & ~(lane_mask(mem_ls) << (8 * mem_addr[1:0])))
                                 | ((mem_din << (8 * mem_addr[1:0])) & (lane_mask(mem_ls) << (8 * mem_addr[1:0])));
    end

    function automatic int unsigned acc_size(input logic [3:0] ls);
        case (ls)
            4'b0000:          return 4;
            4'b1000, 4'b0010: return 2;
            4'b0100, 4'b0001: return 1;
            default:          return 0;
        endcase
    endfunction

    function automatic bit acc_bad(input logic [3:0] ls, input logic [31:0] a);
        int unsigned s;
        s = acc_size(ls);
        return (s == 0) || ((a % s) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [3:0] ls);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < int'(acc_size(ls)); k++)
            v = v | (32'(ref_b[(a + k) % 256]) << (8 * k));
        if (ls == 4'b1000 && v[15]) v = v | 32'hFFFF_0000;
        if (ls == 4'b0100 && v[7])  v = v | 32'hFFFF_FF00;
        return v;
    endfunction

    // Transaction-level reference: a grant opens a 3-cycle slot; write at slot+1, response at slot+2.
    int          cyc = 0;
    int          next_free = 0;
    bit          pref = 1'b0;
    bit          acc_v = 1'b0, acc_we, acc_err, acc_idx;
    int          acc_cyc;
    logic [31:0] acc_addr, acc_wdata;
    logic [3:0]  acc_ls;
    bit          rsp_v = 1'b0, rsp_err, rsp_load, rsp_idx;
    int          rsp_cyc;
    logic [31:0] rsp_val;
    logic [31:0] e_maddr = 0, e_mdin = 0;
    logic [3:0]  e_mls = 0;
    logic [31:0] e_rdata [2] = '{32'h0, 32'h0};

    initial begin
        bit          exp_wr, want, win;
        logic [1:0]  ev, ee;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                check_eq("rst_gnt", {gnt1, gnt0}, 0);
                check_eq("rst_mem_wr", mem_wr, 0);
                check_eq("rst_rvalid", {rvalid1, rvalid0}, 0);
                check_eq("rst_err", {err1, err0}, 0);
                acc_v = 0; rsp_v = 0; next_free = cyc + 1; pref = 0;
                e_maddr = 0; e_mdin = 0; e_mls = 0;
                e_rdata[0] = 0; e_rdata[1] = 0;
            end else begin
                exp_wr = 0;
                if (acc_v && cyc == acc_cyc) begin
                    exp_wr  = acc_we && !acc_err;
                    rsp_val = 0;
                    if (!acc_err) begin
                        if (acc_we) begin
                            for (int k = 0; k < int'(acc_size(acc_ls)); k++)
                                ref_b[(acc_addr + k) % 256] = 8'(acc_wdata >> (8 * k));
                        end else begin
                            rsp_val = ref_load(acc_addr, acc_ls);
                        end
                    end
                    rsp_v = 1; rsp_cyc = cyc + 1; rsp_idx = acc_idx;
                    rsp_err = acc_err; rsp_load = !acc_we; acc_v = 0;
                end
                check_eq("mem_wr", mem_wr, exp_wr);
                check_eq("mem_addr", mem_addr, e_maddr);
                check_eq("mem_din", mem_din, e_mdin);
                check_eq("mem_ls", mem_ls, e_mls);

                ev = 0; ee = 0;
                if (rsp_v && cyc == rsp_cyc) begin
                    ev[rsp_idx] = 1'b1;
                    ee[rsp_idx] = rsp_err;
                    if (rsp_err)       e_rdata[rsp_idx] = 0;
                    else if (rsp_load) e_rdata[rsp_idx] = rsp_val;
                    rsp_v = 0;
                end
                check_eq("rvalid", {rvalid1, rvalid0}, ev);
                check_eq("err", {err1, err0}, ee);
                check_eq("rdata0", rdata0, e_rdata[0]);
                check_eq("rdata1", rdata1, e_rdata[1]);

                want = (cyc >= next_free) && (req0 || req1);
`ifdef DM_ARB_RR_EN
                win = (req0 && req1) ? pref : !req0;
`else
                win = !req0;
`endif
                check_eq("gnt", {gnt1, gnt0}, want ? (win ? 2 : 1) : 0);
                if (gnt0) gnt_log.push_back(0);
                if (gnt1) gnt_log.push_back(1);
                if (want) begin
                    acc_v     = 1; acc_cyc = cyc + 1; acc_idx = win;
                    acc_we    = win ? we1 : we0;
                    acc_addr  = win ? addr1 : addr0;
                    acc_wdata = win ? wdata1 : wdata0;
                    acc_ls    = win ? ls1 : ls0;
                    acc_err   = acc_bad(acc_ls, acc_addr);
                    e_maddr = acc_addr; e_mdin = acc_wdata; e_mls = acc_ls;
                    next_free = cyc + 3;
                    pref = !win;
                end
            end
        end
    end

    task automatic set_req(input int n, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] ls);
        if (n == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; ls0 = ls; end
        else        begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; ls1 = ls; end
    endtask

    task automatic new_txn(input int n);
        logic [3:0]  ls;
        logic [31:0] a;
        logic [3:0]  codes [6];
        codes = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
        ls = codes[$urandom_range(0, 5)];
        if ($urandom_range(0, 7) == 0) ls = 4'($urandom);
        a = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        set_req(n, 1'($urandom), a, $urandom, ls);
    endtask

    task automatic issue(input int n, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] ls);
        bit got;
        set_req(n, we, a, d, ls);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (n == 0) ? gnt0 : gnt1;
        end
        if (!got) check_eq("issue_gnt_timeout", 0, 1);
        @(posedge clk); #1;
        if (n == 0) req0 = 0; else req1 = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          got;
        logic [1:0]  g;
        rst = 1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; ls0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; ls1 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        issue(0, 1, 32'h10, 32'hDEAD_BEEF, 4'b0000);
        issue(0, 0, 32'h10, 32'h0, 4'b0000);
        check_eq("word_load_rdata0", rdata0, 32'hDEAD_BEEF);

        issue(1, 0, 32'h13, 32'h0, 4'b1000);
        check_eq("misaligned_half_rdata1", rdata1, 32'h0);

        issue(0, 1, 32'h20, 32'h1234_5678, 4'b0110);

        issue(0, 1, 32'h10, 32'h0000_8000, 4'b0000);
        issue(0, 0, 32'h11, 32'h0, 4'b0001);
        check_eq("byte_unsigned_rdata0", rdata0, 32'h0000_0080);

        // Reset lands while a store is in ACCESS; the next request is taken right after.
        set_req(0, 1, 32'h40, 32'hCAFE_F00D, 4'b0000);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = gnt0;
        end
        if (!got) check_eq("rst_test_gnt_timeout", 0, 1);
        @(posedge clk); #1;
        rst = 1; req0 = 0;
        @(posedge clk); #1;
        rst = 0;
        set_req(1, 0, 32'h40, 32'h0, 4'b0000);
        @(negedge clk);
        check_eq("regrant_after_rst", gnt1, 1);
        @(posedge clk); #1;
        req1 = 0;
        repeat (3) @(posedge clk);
        #1;

        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        gnt_log.delete();
        set_req(0, 0, 32'h10, 32'h0, 4'b0000);
        set_req(1, 0, 32'h20, 32'h0, 4'b0000);
        for (int i = 0; i < 60 && gnt_log.size() < 4; i++) begin
            @(posedge clk); #1;
        end
        req0 = 0; req1 = 0;
        check_eq("contention_grants", gnt_log.size() >= 4, 1);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
`ifdef DM_ARB_RR_EN
            check_eq("contention_order", gnt_log[i], i % 2);
`else
            check_eq("contention_order", gnt_log[i], 0);
`endif
        end
        repeat (4) @(posedge clk);
        #1;

        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            g = {gnt1, gnt0};
            @(posedge clk); #1;
            if (req0 && g[0]) req0 = 0;
            if (req1 && g[1]) req1 = 0;
            if (!req0 && $urandom_range(0, 2) == 0) new_txn(0);
            if (!req1 && $urandom_range(0, 2) == 0) new_txn(1);
        end
        req0 = 0; req1 = 0;
        repeat (5) @(posedge clk);
        #1;

        for (int w = 0; w < 64; w++)
            check_eq("mem_final", phys[w], {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
